// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive path and the CPU core.
//   BYTE_W          : width of a UART character.
//   UART_BIT_PERIOD : clocks per bit at 12 MHz / 9600 baud.
//   RX_FIFO_DEPTH   : default depth of the receive byte FIFO.
//   CR, SP          : ASCII codes the CPU compare logic matches against.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int UART_BIT_PERIOD = 1250;
  localparam int RX_FIFO_DEPTH   = 16;

  localparam logic [BYTE_W-1:0] CR = 8'h0D;
  localparam logic [BYTE_W-1:0] SP = 8'h20;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Byte FIFO between the UART receiver and the CPU IN-instruction path.
// Upstream it drains the receiver with a level-ready / pulse-ack handshake;
// downstream it presents first-word-fall-through data with the same style.
//
// Parameters:
//   DEPTH  : number of byte entries, power of two, 2..256.
//   ADDR_W : pointer width, derived from DEPTH.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset.
//   up_ready   : receiver holds a byte (level, held until acked).
//   up_data    : receiver byte, valid while up_ready is high.
//   up_ack     : registered one-cycle pulse consuming the receiver byte.
//   dn_ready   : FIFO non-empty, dn_data is valid.
//   dn_data    : head byte (first-word-fall-through).
//   dn_ack     : one-cycle pulse from the CPU popping the head.
//   flush      : synchronous clear of contents and overrun state.
//   ovr_clr    : clears the sticky overrun flag.
//   level      : current entry count, 0..DEPTH.
//   overrun    : sticky, a byte was dropped because the FIFO was full.
//   ovr_cnt    : saturating dropped-byte count (only with the macro below).
//
// Build option:
//   UART_RX_FIFO_OVR_CNT_EN : when defined, adds the ovr_cnt output.
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = RX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_ready,
  input  logic [BYTE_W-1:0] up_data,
  output logic              up_ack,
  output logic              dn_ready,
  output logic [BYTE_W-1:0] dn_data,
  input  logic              dn_ack,
  input  logic              flush,
  input  logic              ovr_clr,
  output logic [ADDR_W:0]   level,
  output logic              overrun
`ifdef UART_RX_FIFO_OVR_CNT_EN
  ,
  output logic [7:0]        ovr_cnt
`endif
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic push;
  logic full;
  logic pop;
  logic store;
  logic drop;

  // The receiver lowers up_ready one cycle after our ack, so a byte is only
  // taken while no ack is outstanding; otherwise it would be captured twice.
  assign push  = up_ready & ~up_ack;
  assign full  = (level == FULL_LEVEL);
  assign pop   = dn_ack & (level != '0);
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign store = push & (~full | dn_ack);
  assign drop  = push & full & ~dn_ack;

  assign dn_ready = (level != '0);
  assign dn_data  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_ack  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      // Every push condition is acked, even when the byte is discarded.
      up_ack <= push;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        overrun <= 1'b0;
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (store) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        case ({store, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        // A drop in the same cycle as ovr_clr keeps the flag set.
        if (drop)         overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // once level says an entry is valid, and leaving it unreset keeps it a
  // plain register file.
  always_ff @(posedge clk) begin
    if (!flush && store) mem[wr_ptr] <= up_data;
  end

`ifdef UART_RX_FIFO_OVR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
    end else if (flush) begin
      ovr_cnt <= '0;
    end else if (drop) begin
      if (ovr_clr)                ovr_cnt <= 8'd1;
      else if (ovr_cnt != 8'hFF)  ovr_cnt <= ovr_cnt + 8'd1;
    end else if (ovr_clr) begin
      ovr_cnt <= '0;
    end
  end
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. A queue-based reference model tracks
// the expected contents, level, ack and overrun state; a monitor compares the
// DUT against it on every falling edge and checks popped bytes in order.
// Define UART_RX_FIFO_OVR_CNT_EN to also check the dropped-byte counter.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          up_ready = 1'b0;
  logic [7:0]    up_data  = 8'h00;
  logic          dn_ack   = 1'b0;
  logic          flush    = 1'b0;
  logic          ovr_clr  = 1'b0;
  logic          up_ack;
  logic          dn_ready;
  logic [7:0]    dn_data;
  logic [LW-1:0] level;
  logic          overrun;
`ifdef UART_RX_FIFO_OVR_CNT_EN
  logic [7:0]    ovr_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  byte unsigned sb_q[$];
  int           m_level = 0;
  bit           m_ack   = 1'b0;
  bit           m_ovr   = 1'b0;
  int           m_cnt   = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_ready (up_ready),
    .up_data  (up_data),
    .up_ack   (up_ack),
    .dn_ready (dn_ready),
    .dn_data  (dn_data),
    .dn_ack   (dn_ack),
    .flush    (flush),
    .ovr_clr  (ovr_clr),
    .level    (level),
    .overrun  (overrun)
`ifdef UART_RX_FIFO_OVR_CNT_EN
    ,
    .ovr_cnt  (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the behavioural model, evaluated on pre-edge inputs.
  task automatic model_step();
    bit push;
    bit store;
    bit pop;
    int lv;
    push  = up_ready && !m_ack;
    m_ack = push;
    if (flush) begin
      sb_q.delete();
      m_level = 0;
      m_ovr   = 1'b0;
      m_cnt   = 0;
    end else begin
      lv    = m_level;
      pop   = dn_ack && (lv > 0);
      store = push && ((lv < DEPTH) || dn_ack);
      if (store) sb_q.push_back(up_data);
      m_level = lv + int'(store) - int'(pop);
      if (push && !store) begin
        m_ovr = 1'b1;
        m_cnt = ovr_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (ovr_clr) begin
        m_ovr = 1'b0;
        m_cnt = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sb_q.delete();
        m_level = 0;
        m_ack   = 1'b0;
        m_ovr   = 1'b0;
        m_cnt   = 0;
      end else begin
        model_step();
      end
    end
  end

  // Monitor: status every cycle, popped data against the scoreboard queue.
  initial begin
    byte unsigned exp_b;
    forever begin
      @(negedge clk);
      check("up_ack",   up_ack,   m_ack);
      check("level",    level,    m_level);
      check("dn_ready", dn_ready, m_level > 0);
      check("overrun",  overrun,  m_ovr);
`ifdef UART_RX_FIFO_OVR_CNT_EN
      check("ovr_cnt",  ovr_cnt,  m_cnt);
`endif
      if (rst_n && dn_ack && !flush && (m_level > 0)) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dn_data: popped 0x%0h, expected nothing at %0t", dn_data, $time);
        end else begin
          exp_b = sb_q.pop_front();
          check("dn_data", dn_data, exp_b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver model: ready held until one cycle after the ack.
  // mode: 0 plain, 1 with dn_ack, 2 with flush, 3 with ovr_clr on the push edge.
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit got;
    got      = 1'b0;
    up_ready = 1'b1;
    up_data  = b;
    dn_ack   = (mode == 1);
    flush    = (mode == 2);
    ovr_clr  = (mode == 3);
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      dn_ack  = 1'b0;
      flush   = 1'b0;
      ovr_clr = 1'b0;
      if (up_ack) got = 1'b1;
    end
    check("ack_seen", got, 1);
    tick();
    up_ready = 1'b0;
  endtask

  task automatic pop_one();
    dn_ack = 1'b1;
    tick();
    dn_ack = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic pulse_ovr_clr();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
  endtask

  initial begin
    byte unsigned head;
    int r;
    int m;

    // Reset then idle
    #2 rst_n = 1'b0;
    #1;
    check("rst_up_ack",   up_ack,   0);
    check("rst_level",    level,    0);
    check("rst_dn_ready", dn_ready, 0);
    check("rst_overrun",  overrun,  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) tick();
    check("idle_level", level, 0);

    // Reset while an ack is in flight
    up_ready = 1'b1;
    up_data  = 8'hEE;
    tick();
    check("ack_before_rst", up_ack, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_up_ack",  up_ack,  0);
    check("midrst_level",   level,   0);
    check("midrst_dn_ready", dn_ready, 0);
    up_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single byte
    send_byte(8'h31, 0);
    check("single_level", level, 1);
    check("single_data",  dn_data, 8'h31);
    pop_one();
    check("single_empty", dn_ready, 0);

    // Fill and wrap
    for (int i = 0; i < 16; i++) send_byte(8'h41 + 8'(i), 0);
    check("peak_level", level, 16);
    repeat (8) pop_one();
    for (int i = 0; i < 8; i++) send_byte(8'h61 + 8'(i), 0);
    check("wrap_level", level, 16);
    repeat (16) pop_one();
    check("wrap_empty", level, 0);

    // Overrun, drop-newest
    head = 8'($urandom);
    send_byte(head, 0);
    for (int i = 1; i < 16; i++) send_byte(8'($urandom), 0);
    send_byte(8'h7A, 0);
    send_byte(8'h7B, 0);
    check("ovr_flag",  overrun, 1);
    check("ovr_level", level,   16);
    check("ovr_head",  dn_data, head);
`ifdef UART_RX_FIFO_OVR_CNT_EN
    check("ovr_cnt_2", ovr_cnt, 2);
`endif

    // Simultaneous push and pop
    pulse_ovr_clr();
    check("ovr_cleared", overrun, 0);
    send_byte(8'h55, 1);
    check("full_pushpop_level", level,   16);
    check("full_pushpop_ovr",   overrun, 0);
    repeat (16) pop_one();
    check("drained", level, 0);
    pop_one();
    check("empty_pop_ignored", level, 0);
    send_byte(8'h5A, 1);
    check("empty_pushpop_level", level, 1);
    pop_one();

    // Flush and clear
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 0);
    send_byte(8'hC3, 0);
    repeat (11) pop_one();
    check("pre_flush_level", level,   5);
    check("pre_flush_ovr",   overrun, 1);
    pulse_flush();
    check("flush_level", level,   0);
    check("flush_ovr",   overrun, 0);
    send_byte(8'h99, 2);
    check("flush_push_discard", level, 0);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 0);
    send_byte(8'hD4, 3);
    check("set_beats_clr", overrun, 1);
`ifdef UART_RX_FIFO_OVR_CNT_EN
    check("cnt_inc_beats_clr", ovr_cnt, 1);
    for (int i = 0; i < 257; i++) send_byte(8'($urandom), 0);
    check("cnt_saturates", ovr_cnt, 255);
`endif
    pulse_ovr_clr();
    check("clr_alone", overrun, 0);
    pulse_flush();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        m = $urandom_range(0, 19);
        send_byte(8'($urandom), (m < 14) ? 0 : (m < 18) ? 1 : (m == 18) ? 3 : 2);
      end else if (r < 8) begin
        pop_one();
      end else if (r == 8) begin
        tick();
      end else begin
        pulse_ovr_clr();
      end
    end
    while (level != 0 && n_cmp < 1_000_000) pop_one();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx_fifo
